// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies,
// FSM state type and op classification helpers.
package mdu_pkg;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Ops that occupy the unit for several cycles
    function automatic logic is_long_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface mdu_if;
    import mdu_pkg::*;

    logic [MD_OP_W-1:0] md_op;
    logic [31:0]        a;
    logic [31:0]        b;
    logic               busy;
    logic [31:0]        hi;
    logic [31:0]        lo;

    modport master (output md_op, output a, output b, input busy, input hi, input lo);
    modport slave  (input md_op, input a, input b, output busy, output hi, output lo);

endinterface

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath working on the operands latched at issue.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [MD_OP_W-1:0] i_op,
    input  logic [31:0]        i_a,
    input  logic [31:0]        i_b,
    output logic [31:0]        o_hi_res,
    output logic [31:0]        o_lo_res,
    output logic               o_div0
);

    logic signed [31:0] w_a_s;
    logic signed [31:0] w_b_s;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_signed_div;
    logic        [31:0] w_mag_a;
    logic        [31:0] w_mag_b;
    logic        [31:0] w_dvsr;
    logic        [31:0] w_quo_mag;
    logic        [31:0] w_rem_mag;
    logic               w_neg_q;
    logic               w_neg_r;

    assign w_a_s    = i_a;
    assign w_b_s    = i_b;
    assign w_prod_s = 64'(w_a_s) * 64'(w_b_s);
    assign w_prod_u = 64'(i_a) * 64'(i_b);

    // Signed divide runs on magnitudes; -2^31 / -1 falls out as 0x80000000 rem 0
    assign w_signed_div = (i_op == MD_DIV);
    assign w_mag_a      = (w_signed_div && i_a[31]) ? (~i_a + 32'd1) : i_a;
    assign w_mag_b      = (w_signed_div && i_b[31]) ? (~i_b + 32'd1) : i_b;
    assign o_div0       = (i_b == 32'd0);
    assign w_dvsr       = o_div0 ? 32'd1 : w_mag_b;
    assign w_quo_mag    = w_mag_a / w_dvsr;
    assign w_rem_mag    = w_mag_a % w_dvsr;
    assign w_neg_q      = w_signed_div && (i_a[31] ^ i_b[31]);
    assign w_neg_r      = w_signed_div && i_a[31];

    always_comb begin
        o_hi_res = 32'd0;
        o_lo_res = 32'd0;
        case (i_op)
            MD_MULT:  {o_hi_res, o_lo_res} = w_prod_s;
            MD_MULTU: {o_hi_res, o_lo_res} = w_prod_u;
            MD_DIV, MD_DIVU: begin
                o_lo_res = w_neg_q ? (~w_quo_mag + 32'd1) : w_quo_mag;
                o_hi_res = w_neg_r ? (~w_rem_mag + 32'd1) : w_rem_mag;
            end
            default: begin
                o_hi_res = 32'd0;
                o_lo_res = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: IDLE/RUN latency FSM, operand latches and the HI/LO registers.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [MD_OP_W-1:0] r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_latch;
    logic               w_commit;
    logic               w_wr_hi_mt;
    logic               w_wr_lo_mt;
    logic               w_busy_nxt;
    logic [31:0]        w_hi_res;
    logic [31:0]        w_lo_res;
    logic               w_div0;

    mdu_calc u_calc (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_hi_res (w_hi_res),
        .o_lo_res (w_lo_res),
        .o_div0   (w_div0)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (is_long_op(bus.md_op)) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == '0)            w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // busy is registered from the next state so it never depends on inputs combinationally
    always_comb begin
        w_latch    = 1'b0;
        w_commit   = 1'b0;
        w_wr_hi_mt = 1'b0;
        w_wr_lo_mt = 1'b0;
        w_busy_nxt = (w_state_nxt == ST_RUN);
        if (r_state == ST_IDLE) begin
            w_latch    = is_long_op(bus.md_op);
            w_wr_hi_mt = (bus.md_op == MD_MTHI);
            w_wr_lo_mt = (bus.md_op == MD_MTLO);
        end else if (r_cnt == '0) begin
            w_commit   = !(is_div_op(r_op) && w_div0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= MD_NONE;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
        end else if (w_latch) begin
            r_cnt <= is_div_op(bus.md_op) ? DIV_LOAD : MULT_LOAD;
            r_op  <= bus.md_op;
            r_a   <= bus.a;
            r_b   <= bus.b;
        end else if ((r_state == ST_RUN) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (w_commit) begin
                r_hi <= w_hi_res;
                r_lo <= w_lo_res;
            end
            if (w_wr_hi_mt) r_hi <= bus.a;
            if (w_wr_lo_mt) r_lo <= bus.a;
        end
    end

    assign bus.busy = r_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed plan cases plus random ops against a 64-bit arithmetic model.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    mdu_if bus();

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one accepted op, using plain 64-bit arithmetic
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            MD_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            MD_MULTU: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
            MD_DIV:   if (b != 0) begin p = sa / sb; m_lo = p[31:0]; p = sa % sb; m_hi = p[31:0]; end
            MD_DIVU:  if (b != 0) begin p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0]; end
            MD_MTHI:  m_hi = a;
            MD_MTLO:  m_lo = a;
            default:  ;
        endcase
    endtask

    function automatic int op_len(input logic [2:0] op);
        if (op == MD_DIV || op == MD_DIVU) return DC;
        if (op == MD_MULT || op == MD_MULTU) return MC;
        return 0;
    endfunction

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    // Issue one op, scramble operands right after the issue edge, then check latency and HI/LO
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        @(negedge clk);
        bus.md_op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.md_op = MD_NONE; bus.a = $urandom; bus.b = $urandom;
        model_apply(op, a, b);
        wait_idle(cyc);
        check("busy_len", 32'(cyc), 32'(op_len(op)));
        check("hi", bus.hi, m_hi);
        check("lo", bus.lo, m_lo);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        bus.md_op = MD_NONE; bus.a = 32'd0; bus.b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        @(negedge clk); reset = 1'b0;

        run_op(MD_MULT, 32'hFFFFFFFE, 32'd3);
        check("mult_hi_const", bus.hi, 32'hFFFFFFFF);
        check("mult_lo_const", bus.lo, 32'hFFFFFFFA);
        run_op(MD_MULTU, 32'hFFFFFFFE, 32'd3);
        check("multu_hi_const", bus.hi, 32'h00000002);
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
        check("div_lo_const", bus.lo, 32'hFFFFFFFD);
        check("div_hi_const", bus.hi, 32'hFFFFFFFF);
        run_op(MD_DIVU, 32'd7, 32'd2);
        check("divu_lo_const", bus.lo, 32'd3);
        check("divu_hi_const", bus.hi, 32'd1);
        run_op(MD_MTHI, 32'h12345678, 32'd0);
        check("mthi_const", bus.hi, 32'h12345678);
        run_op(MD_DIV, 32'd99, 32'd0);
        check("div0_hi_const", bus.hi, 32'h12345678);
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        check("ovf_lo_const", bus.lo, 32'h80000000);
        check("ovf_hi_const", bus.hi, 32'd0);
        run_op(MD_MULT, 32'd5, 32'd6);
        check("hold_lo_const", bus.lo, 32'd30);
        check("hold_hi_const", bus.hi, 32'd0);

        // Ops presented while busy must be ignored
        @(negedge clk);
        bus.md_op = MD_MULT; bus.a = 32'h00012345; bus.b = 32'h00067890;
        @(posedge clk); #1;
        model_apply(MD_MULT, 32'h00012345, 32'h00067890);
        bus.md_op = MD_DIV; bus.a = 32'd100; bus.b = 32'd3;
        @(posedge clk); #1;
        check("ign_busy1", 32'(bus.busy), 32'd1);
        bus.md_op = MD_MTLO; bus.a = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("ign_busy2", 32'(bus.busy), 32'd1);
        bus.md_op = MD_NONE;
        wait_idle(cyc);
        check("ign_len", 32'(cyc), 32'(MC - 2));
        check("ign_hi", bus.hi, m_hi);
        check("ign_lo", bus.lo, m_lo);
        repeat (DC + 2) @(posedge clk);
        #1;
        check("ign_busy_after", 32'(bus.busy), 32'd0);
        check("ign_lo_after", bus.lo, m_lo);

        for (int i = 0; i < 24; i++) begin
            logic [2:0] op;
            logic [31:0] ra, rb;
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(op, ra, rb);
        end

        // Reset in the middle of a divide aborts it without writing HI/LO
        run_op(MD_MTHI, 32'hA5A5A5A5, 32'd0);
        run_op(MD_MTLO, 32'h5A5A5A5A, 32'd0);
        @(negedge clk);
        bus.md_op = MD_DIVU; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.md_op = MD_NONE;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        m_hi = 32'd0; m_lo = 32'd0;
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_hi", bus.hi, m_hi);
        check("rst_mid_lo", bus.lo, m_lo);
        @(negedge clk); reset = 1'b0;
        repeat (DC + 2) @(posedge clk);
        #1;
        check("rst_late_busy", 32'(bus.busy), 32'd0);
        check("rst_late_hi", bus.hi, 32'd0);
        check("rst_late_lo", bus.lo, 32'd0);

        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit on the execute side of the MIPS datapath, directly downstream of the register file. It consumes the RF read ports (RD1 → `a`, RD2 → `b`) and executes mult, multu, div, divu, mthi and mtlo. HI/LO are architectural state held here; mfhi/mflo read them combinationally. `busy` models multi-cycle latency so the hazard unit can stall later md instructions.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy duration for mult/multu (≥1)
- `DIV_CYCLES`, 10, busy duration for div/divu (≥1)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `md_op`  in  3  operation issue; 0 = none (encodings in package)
- `a`  in  32  operand rs (from RD1)
- `b`  in  32  operand rt (from RD2)
- `busy`  out  1  operation in flight
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- Op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, 7 is reserved and treated as NONE.
- Issue: `md_op`≠NONE with `busy`=0 is sampled at a rising edge. With `busy`=1, any op is ignored (no state change); the hazard unit prevents this case.
- MULT: {hi,lo} ← signed 64-bit a×b. MULTU: unsigned a×b.
- DIV: lo ← signed quotient, truncated toward zero; hi ← remainder with the sign of the dividend. DIVU: unsigned quotient/remainder.
- Divide by zero (b=0, DIV or DIVU): busy runs the full DIV_CYCLES; hi/lo remain unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO: hi (resp. lo) ← a at the issuing edge. busy is not asserted.
- The result is computed from operands latched at issue. Later changes to `a`/`b` have no effect.
- States: IDLE, RUN. Transitions:
  - IDLE→RUN on a mult/div issue; counter loaded with N−1 (N = MULT_CYCLES or DIV_CYCLES).
  - RUN: counter decrements each edge. At the edge where counter=0, hi/lo take the pending result and the state returns to IDLE.
- Reset: state=IDLE, counter=0, busy=0, hi=0, lo=0, pending result cleared. Reset mid-RUN aborts the operation with no write to hi/lo. Reset has priority over any simultaneous issue.

## Timing
- Issue at edge k: busy=1 from after edge k until edge k+N. At edge k+N, hi/lo update and busy=0 in the same cycle. busy is high for exactly N cycles.
- New issue is accepted at edge k+N+1 at the earliest (the first edge with busy=0). There is no back-to-back overlap.
- MTHI/MTLO issued at edge k: new value is visible on hi/lo after edge k.
- hi/lo outputs are register outputs, with no combinational path from inputs.
- busy is a register output.

## Structure
- Package `mdu_pkg`: md_op encoding localparams (MD_NONE … MD_MTLO), op width 3, default cycle counts.
- Sub-module `mdu_calc`: purely combinational. Takes latched op, a, b and produces 64-bit {hi_res, lo_res} plus a div-by-zero flag.
- Top `mdu`: IDLE/RUN FSM, counter, operand/op latches, HI/LO registers.

## Test plan
- MULT a=0xFFFFFFFE(−2), b=3 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9(−7), b=2 → busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- MTHI a=0x12345678 → hi=0x12345678 next cycle, busy stays 0. Then DIV with b=0 → busy 10 cycles, hi still 0x12345678.
- Issue MULT, then present DIV and MTLO while busy=1 → both ignored; final hi/lo equal the MULT result only.
- Issue DIVU, assert reset at cycle 4 → busy=0, hi=lo=0 after that edge, and no later write.
- Operand hold: issue MULT a=5, b=6, then change a/b to 0xFFFFFFFF on the next cycle → lo=30, hi=0.
